// File: rtl/inv_round_tail_if.sv
// rtl/inv_round_tail_if.sv - beat handshake bundle for the inverse-round tail
interface inv_round_tail_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         out_last;
  logic [3:0]   out_round;
  logic         err_seq;

  modport master (
    output in_valid, in_state, in_key, in_last, out_ready,
    input  in_ready, out_valid, out_state, out_last, out_round, err_seq
  );

  modport slave (
    input  in_valid, in_state, in_key, in_last, out_ready,
    output in_ready, out_valid, out_state, out_last, out_round, err_seq
  );
endinterface

// File: rtl/inv_round_tail.sv
// rtl/inv_round_tail.sv - AddRoundKey + InvMixColumns stage feeding a 2-entry result FIFO
module inv_round_tail (
  input logic              clk,
  input logic              rst_n,
  inv_round_tail_if.slave  bus
);
  localparam logic [3:0] LAST_ROUND = 4'd9;

  typedef struct packed {
    logic [127:0] state;
    logic         last;
    logic [3:0]   round;
  } entry_t;

  entry_t       mem_q [2];
  entry_t       head;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q;
  logic [3:0]   rcnt_q, rcnt_d;
  logic         err_q, err_d;
  logic         out_valid;
  logic         push, pop;
  logic [127:0] t;
  logic [127:0] mixed;
  logic [127:0] result;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are row 0 in the MSB; coefficient rows are {0e,0b,0d,09} rotated.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    t     = bus.in_state ^ bus.in_key;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end
    result = bus.in_last ? t : mixed;
  end

  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rcnt_d   = rcnt_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      rcnt_d   = (bus.in_last || rcnt_q == LAST_ROUND) ? 4'd0 : rcnt_q + 4'd1;
      // A last beat must land on round 9, and round 9 must be a last beat.
      err_d    = err_q | (bus.in_last != (rcnt_q == LAST_ROUND));
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rcnt_q     <= 4'd0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rcnt_q     <= rcnt_d;
      err_q      <= err_d;
      // Registered so in_ready never sees out_ready combinationally.
      in_ready_q <= (count_d != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {result, bus.in_last, rcnt_q};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_state = out_valid ? head.state : 128'd0;
  assign bus.out_last  = out_valid ? head.last  : 1'b0;
  assign bus.out_round = out_valid ? head.round : 4'd0;
  assign bus.err_seq   = err_q;
endmodule
